// File: rtl/dtm_jtag_if.sv
// DMI trivial bus between the JTAG DTM (master) and the Debug Module (slave).
// Handshake: master raises dmi_start for one cycle with op/address/data valid and holds them; slave answers with a one-cycle dmi_finish (dmi_data_i valid in that cycle).
interface dmi_if #(
    parameter int ABITS = 7
) ();
    logic             dmi_start;
    logic             dmi_finish;
    logic [1:0]       dmi_op;
    logic [ABITS-1:0] dmi_address;
    logic [31:0]      dmi_data_o;
    logic [31:0]      dmi_data_i;

    modport master (
        output dmi_start, dmi_op, dmi_address, dmi_data_o,
        input  dmi_finish, dmi_data_i
    );

    modport slave (
        input  dmi_start, dmi_op, dmi_address, dmi_data_o,
        output dmi_finish, dmi_data_i
    );
endinterface

// File: rtl/dtm_jtag.sv
// RISC-V JTAG DTM (v0.13): oversampled TAP, IDCODE/DTMCS/DMI/BYPASS, DMI request FSM.
// Optional DMI_TIMEOUT_EN: abandon a DMI access after DMI_TIMEOUT cycles and report dmistat=2.
module dtm_jtag #(
    parameter logic [31:0] IDCODE      = 32'h0000_0001,
    parameter int          ABITS       = 7,
    parameter int          DMI_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tck,
    input  logic       tms,
    input  logic       tdi,
    output logic       tdo,
    dmi_if.master      dmi,
    output logic [3:0] dbg_tap_state,
    output logic [1:0] dbg_dmi_state
);
    localparam int DRW = ABITS + 34;

    // IEEE 1149.1 conventional state codes
    typedef enum logic [3:0] {
        TLR    = 4'hF, RTI    = 4'hC,
        SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR = 4'h2, EX1_DR = 4'h1,
        PA_DR  = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5,
        SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR = 4'hA, EX1_IR = 4'h9,
        PA_IR  = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
    } tap_t;

    typedef enum logic [1:0] {D_IDLE = 2'd0, D_REQ = 2'd1, D_WAIT = 2'd2} dmi_st_t;

    logic [2:0]       tck_q;
    logic [1:0]       tms_q, tdi_q;
    logic             tck_rise, tck_fall, tms_i, tdi_i;
    tap_t             tap_state, tap_next;
    logic [4:0]       ir, ir_shift;
    logic [DRW-1:0]   dr_shift, dr_shift_nxt, dr_capture;
    logic             ir_idcode, ir_dtmcs, ir_dmi;
    logic [1:0]       dmistat;
    dmi_st_t          dmi_state, dmi_next;
    logic [ABITS-1:0] addr_q;
    logic [31:0]      wdata_q, cap_data;
    logic [1:0]       op_q;
    logic             busy, finish_eff, fsm_free, upd_dr, dmi_upd, dtmcs_upd;
    logic             cap_busy, hardreset, accept, timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tck_q <= '0;
            tms_q <= '0;
            tdi_q <= '0;
        end else begin
            tck_q <= {tck_q[1:0], tck};
            tms_q <= {tms_q[0], tms};
            tdi_q <= {tdi_q[0], tdi};
        end
    end

    assign tck_rise = tck_q[1] & ~tck_q[2];
    assign tck_fall = ~tck_q[1] & tck_q[2];
    assign tms_i    = tms_q[1];
    assign tdi_i    = tdi_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        tap_state <= TLR;
        else if (tck_rise) tap_state <= tap_next;
    end

    always_comb begin
        tap_next = tap_state;
        case (tap_state)
            TLR:    tap_next = tms_i ? TLR    : RTI;
            RTI:    tap_next = tms_i ? SEL_DR : RTI;
            SEL_DR: tap_next = tms_i ? SEL_IR : CAP_DR;
            CAP_DR: tap_next = tms_i ? EX1_DR : SH_DR;
            SH_DR:  tap_next = tms_i ? EX1_DR : SH_DR;
            EX1_DR: tap_next = tms_i ? UPD_DR : PA_DR;
            PA_DR:  tap_next = tms_i ? EX2_DR : PA_DR;
            EX2_DR: tap_next = tms_i ? UPD_DR : SH_DR;
            UPD_DR: tap_next = tms_i ? SEL_DR : RTI;
            SEL_IR: tap_next = tms_i ? TLR    : CAP_IR;
            CAP_IR: tap_next = tms_i ? EX1_IR : SH_IR;
            SH_IR:  tap_next = tms_i ? EX1_IR : SH_IR;
            EX1_IR: tap_next = tms_i ? UPD_IR : PA_IR;
            PA_IR:  tap_next = tms_i ? EX2_IR : PA_IR;
            EX2_IR: tap_next = tms_i ? UPD_IR : SH_IR;
            UPD_IR: tap_next = tms_i ? SEL_DR : RTI;
            default: tap_next = TLR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir       <= 5'h01;
            ir_shift <= 5'h00;
        end else begin
            if (tap_state == TLR)                    ir <= 5'h01;
            else if (tck_fall && tap_state == UPD_IR) ir <= ir_shift;
            if (tck_rise && tap_state == CAP_IR)     ir_shift <= 5'b00001;
            else if (tck_rise && tap_state == SH_IR) ir_shift <= {tdi_i, ir_shift[4:1]};
        end
    end

    assign ir_idcode = (ir == 5'h01);
    assign ir_dtmcs  = (ir == 5'h10);
    assign ir_dmi    = (ir == 5'h11);
    assign busy      = (dmi_state != D_IDLE);

    always_comb begin
        dr_capture = '0;
        if (ir_dmi)
            dr_capture = {addr_q, cap_data, (busy ? 2'd3 : dmistat)};
        else if (ir_dtmcs)
            dr_capture[31:0] = {14'b0, 1'b0, 1'b0, 1'b0, 3'd1, dmistat, 6'(ABITS), 4'd1};
        else if (ir_idcode)
            dr_capture[31:0] = IDCODE;
    end

    // tdi enters at the top of whichever register is selected, so one shifter serves all lengths
    always_comb begin
        dr_shift_nxt = dr_shift >> 1;
        if (ir_dmi)                      dr_shift_nxt[DRW-1] = tdi_i;
        else if (ir_dtmcs || ir_idcode)  dr_shift_nxt[31]    = tdi_i;
        else                             dr_shift_nxt[0]     = tdi_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              dr_shift <= '0;
        else if (tck_rise && tap_state == CAP_DR) dr_shift <= dr_capture;
        else if (tck_rise && tap_state == SH_DR)  dr_shift <= dr_shift_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        tdo <= 1'b0;
        else if (tck_fall) tdo <= (tap_state == SH_IR) ? ir_shift[0] :
                                  (tap_state == SH_DR) ? dr_shift[0] : 1'b0;
    end

    assign upd_dr     = tck_fall && (tap_state == UPD_DR);
    assign dmi_upd    = upd_dr && ir_dmi;
    assign dtmcs_upd  = upd_dr && ir_dtmcs;
    assign hardreset  = dtmcs_upd && dr_shift[17];
    assign cap_busy   = tck_rise && (tap_state == CAP_DR) && ir_dmi && busy;
    // A finish arriving with an update is consumed first, freeing the FSM for the new request
    assign finish_eff = (dmi_state == D_REQ || dmi_state == D_WAIT) && dmi.dmi_finish && !hardreset;
    assign fsm_free   = (dmi_state == D_IDLE) || finish_eff;
    assign accept     = dmi_upd && fsm_free && (dmistat == 2'd0) &&
                        (dr_shift[1:0] == 2'd1 || dr_shift[1:0] == 2'd2);

`ifdef DMI_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  tmo_cnt <= '0;
        else if (dmi_state == D_WAIT) tmo_cnt <= tmo_cnt + 16'd1;
        else                         tmo_cnt <= '0;
    end
    assign timeout = (dmi_state == D_WAIT) && !dmi.dmi_finish &&
                     (tmo_cnt == 16'(DMI_TIMEOUT - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dmi_state <= D_IDLE;
        else        dmi_state <= dmi_next;
    end

    always_comb begin
        dmi_next = dmi_state;
        if (hardreset) begin
            dmi_next = D_IDLE;
        end else begin
            case (dmi_state)
                D_IDLE: if (accept) dmi_next = D_REQ;
                D_REQ, D_WAIT: begin
                    if (dmi.dmi_finish)  dmi_next = accept ? D_REQ : D_IDLE;
                    else if (timeout)    dmi_next = D_IDLE;
                    else                 dmi_next = D_WAIT;
                end
                default: dmi_next = D_IDLE;
            endcase
        end
    end

    always_comb begin
        dmi.dmi_start   = (dmi_state == D_REQ);
        dmi.dmi_op      = op_q;
        dmi.dmi_address = addr_q;
        dmi.dmi_data_o  = wdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            op_q     <= '0;
            cap_data <= '0;
        end else begin
            if (finish_eff && op_q == 2'd1) cap_data <= dmi.dmi_data_i;
            if (timeout && op_q == 2'd1)    cap_data <= '0;
            if (accept) begin
                addr_q   <= dr_shift[DRW-1:34];
                wdata_q  <= dr_shift[33:2];
                op_q     <= dr_shift[1:0];
                cap_data <= dr_shift[33:2];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                    dmistat <= 2'd0;
        else if (hardreset || (dtmcs_upd && dr_shift[16])) dmistat <= 2'd0;
        else if (cap_busy || (dmi_upd && !fsm_free))   dmistat <= 2'd3;
        else if (timeout)                              dmistat <= 2'd2;
    end

    assign dbg_tap_state = tap_state;
    assign dbg_dmi_state = dmi_state;
endmodule
